// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;
  localparam int RA_W            = 4;
  localparam int PC_REG          = 15;
  localparam int MEM_TIMEOUT_DEF = 16;

  typedef logic [RA_W-1:0] ra_t;

  typedef enum logic [1:0] {
    FWD_RD      = 2'b00,
    FWD_RESULTW = 2'b01,
    FWD_ALUM    = 2'b10
  } fwd_sel_t;

  localparam ra_t PC_RA = ra_t'(PC_REG);
endpackage

// File: rtl/hazard_if.sv
// Pipeline <-> hazard unit signal bundle; the core is master, the hazard unit slave.
interface hazard_if;
  import hazard_pkg::*;

  ra_t      RA1D, RA2D, WA3D;
  logic     RegWriteD, MemtoRegD;
  logic     RegWriteECond, MemWriteECond, PCSrcE, MemReady;
  fwd_sel_t ForwardAE, ForwardBE;
  logic     StallF, StallD, StallE, StallM;
  logic     FlushD, FlushE, FlushW;
  logic     MemTimeout;

  modport master (
    output RA1D, RA2D, WA3D, RegWriteD, MemtoRegD,
    output RegWriteECond, MemWriteECond, PCSrcE, MemReady,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW, MemTimeout
  );

  modport slave (
    input  RA1D, RA2D, WA3D, RegWriteD, MemtoRegD,
    input  RegWriteECond, MemWriteECond, PCSrcE, MemReady,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW, MemTimeout
  );
endinterface

// File: rtl/fwd_select.sv
// Operand bypass select for one Execute source: Memory result beats Writeback result.
module fwd_select
  import hazard_pkg::*;
(
  input  ra_t      src_i,
  input  ra_t      wa3m_i,
  input  logic     reg_write_m_i,
  input  ra_t      wa3w_i,
  input  logic     reg_write_w_i,
  output fwd_sel_t sel_o
);

  // PC reads always come from the register file path
  always_comb begin
    sel_o = FWD_RD;
    if (src_i == PC_RA) begin
      sel_o = FWD_RD;
    end else if (reg_write_m_i && (wa3m_i == src_i)) begin
      sel_o = FWD_ALUM;
    end else if (reg_write_w_i && (wa3w_i == src_i)) begin
      sel_o = FWD_RESULTW;
    end else begin
      sel_o = FWD_RD;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage core: bypass selects, stall/flush controls
// and a data-memory wait watchdog, driven from a private shadow of E/M/W state.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic    CLK,
  input  logic    RESET,
  hazard_if.slave hz
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  typedef logic [CNT_W-1:0] cnt_t;

  ra_t  ra1e_q, ra1e_d, ra2e_q, ra2e_d, wa3e_q, wa3e_d;
  logic reg_write_e_q, reg_write_e_d, mem_to_reg_e_q, mem_to_reg_e_d;
  ra_t  wa3m_q, wa3m_d;
  logic reg_write_m_q, reg_write_m_d, mem_to_reg_m_q, mem_to_reg_m_d;
  logic mem_access_m_q, mem_access_m_d;
  ra_t  wa3w_q, wa3w_d;
  logic reg_write_w_q, reg_write_w_d;
  cnt_t wait_cnt_q, wait_cnt_d;
  logic timeout_q, timeout_d;

  logic mem_wait_s, load_use_s;
  logic stall_f_s, stall_d_s, stall_e_s, stall_m_s;
  logic flush_d_s, flush_e_s, flush_w_s;
  fwd_sel_t fwd_a_s, fwd_b_s;

  // a load in M is always a memory access, so either flag marks a pending access
  assign mem_wait_s = (mem_access_m_q | mem_to_reg_m_q) & ~hz.MemReady & ~timeout_q;
  assign load_use_s = mem_to_reg_e_q & reg_write_e_q & (wa3e_q != PC_RA)
                    & ((wa3e_q == hz.RA1D) | (wa3e_q == hz.RA2D));

  fwd_select u_fwd_a (
    .src_i(ra1e_q), .wa3m_i(wa3m_q), .reg_write_m_i(reg_write_m_q),
    .wa3w_i(wa3w_q), .reg_write_w_i(reg_write_w_q), .sel_o(fwd_a_s)
  );

  fwd_select u_fwd_b (
    .src_i(ra2e_q), .wa3m_i(wa3m_q), .reg_write_m_i(reg_write_m_q),
    .wa3w_i(wa3w_q), .reg_write_w_i(reg_write_w_q), .sel_o(fwd_b_s)
  );

  // Stall/flush priority: memory wait, then branch, then load-use
  always_comb begin
    stall_f_s = 1'b0;
    stall_d_s = 1'b0;
    stall_e_s = 1'b0;
    stall_m_s = 1'b0;
    flush_d_s = 1'b0;
    flush_e_s = 1'b0;
    flush_w_s = 1'b0;
    if (!RESET) begin
      flush_d_s = 1'b1;
      flush_e_s = 1'b1;
    end else if (mem_wait_s) begin
      stall_f_s = 1'b1;
      stall_d_s = 1'b1;
      stall_e_s = 1'b1;
      stall_m_s = 1'b1;
      flush_w_s = 1'b1;
    end else if (hz.PCSrcE) begin
      flush_d_s = 1'b1;
      flush_e_s = 1'b1;
    end else if (load_use_s) begin
      stall_f_s = 1'b1;
      stall_d_s = 1'b1;
      flush_e_s = 1'b1;
    end else begin
      stall_f_s = 1'b0;
    end
  end

  // Execute shadow: hold, bubble, or capture the Decode instruction
  always_comb begin
    ra1e_d         = ra1e_q;
    ra2e_d         = ra2e_q;
    wa3e_d         = wa3e_q;
    reg_write_e_d  = reg_write_e_q;
    mem_to_reg_e_d = mem_to_reg_e_q;
    if (stall_e_s) begin
      ra1e_d = ra1e_q;
    end else if (flush_e_s) begin
      ra1e_d         = {RA_W{1'b0}};
      ra2e_d         = {RA_W{1'b0}};
      wa3e_d         = {RA_W{1'b0}};
      reg_write_e_d  = 1'b0;
      mem_to_reg_e_d = 1'b0;
    end else begin
      ra1e_d         = hz.RA1D;
      ra2e_d         = hz.RA2D;
      wa3e_d         = hz.WA3D;
      reg_write_e_d  = hz.RegWriteD;
      mem_to_reg_e_d = hz.MemtoRegD;
    end
  end

  // Memory and Writeback shadows plus the wait watchdog
  always_comb begin
    wa3m_d         = wa3m_q;
    reg_write_m_d  = reg_write_m_q;
    mem_to_reg_m_d = mem_to_reg_m_q;
    mem_access_m_d = mem_access_m_q;
    if (stall_m_s) begin
      wa3m_d = wa3m_q;
    end else begin
      wa3m_d         = wa3e_q;
      reg_write_m_d  = hz.RegWriteECond;
      mem_to_reg_m_d = mem_to_reg_e_q;
      mem_access_m_d = mem_to_reg_e_q | hz.MemWriteECond;
    end
    if (flush_w_s) begin
      wa3w_d        = {RA_W{1'b0}};
      reg_write_w_d = 1'b0;
    end else begin
      wa3w_d        = wa3m_q;
      reg_write_w_d = reg_write_m_q;
    end
    if (mem_wait_s) begin
      wait_cnt_d = wait_cnt_q + cnt_t'(1);
    end else begin
      wait_cnt_d = cnt_t'(0);
    end
    timeout_d = timeout_q | (mem_wait_s & (wait_cnt_q == cnt_t'(MEM_TIMEOUT - 1)));
  end

  // Shadow state registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ra1e_q         <= {RA_W{1'b0}};
      ra2e_q         <= {RA_W{1'b0}};
      wa3e_q         <= {RA_W{1'b0}};
      reg_write_e_q  <= 1'b0;
      mem_to_reg_e_q <= 1'b0;
      wa3m_q         <= {RA_W{1'b0}};
      reg_write_m_q  <= 1'b0;
      mem_to_reg_m_q <= 1'b0;
      mem_access_m_q <= 1'b0;
      wa3w_q         <= {RA_W{1'b0}};
      reg_write_w_q  <= 1'b0;
      wait_cnt_q     <= cnt_t'(0);
      timeout_q      <= 1'b0;
    end else begin
      ra1e_q         <= ra1e_d;
      ra2e_q         <= ra2e_d;
      wa3e_q         <= wa3e_d;
      reg_write_e_q  <= reg_write_e_d;
      mem_to_reg_e_q <= mem_to_reg_e_d;
      wa3m_q         <= wa3m_d;
      reg_write_m_q  <= reg_write_m_d;
      mem_to_reg_m_q <= mem_to_reg_m_d;
      mem_access_m_q <= mem_access_m_d;
      wa3w_q         <= wa3w_d;
      reg_write_w_q  <= reg_write_w_d;
      wait_cnt_q     <= wait_cnt_d;
      timeout_q      <= timeout_d;
    end
  end

  assign hz.ForwardAE  = RESET ? fwd_a_s : FWD_RD;
  assign hz.ForwardBE  = RESET ? fwd_b_s : FWD_RD;
  assign hz.StallF     = stall_f_s;
  assign hz.StallD     = stall_d_s;
  assign hz.StallE     = stall_e_s;
  assign hz.StallM     = stall_m_s;
  assign hz.FlushD     = flush_d_s;
  assign hz.FlushE     = flush_e_s;
  assign hz.FlushW     = flush_w_s;
  assign hz.MemTimeout = timeout_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus random traffic,
// all compared against a stage-record reference model.
module tb_hazard_unit;
  import hazard_pkg::*;

  logic CLK = 1'b0;
  logic RESET;
  int   checks = 0;
  int   passed = 0;

  hazard_if hz();

  hazard_unit #(.MEM_TIMEOUT(MEM_TIMEOUT_DEF)) dut (
    .CLK(CLK), .RESET(RESET), .hz(hz)
  );

  always #5 CLK = ~CLK;

  // observed vector: {FwdA, FwdB, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout}
  logic [11:0] obs;
  assign obs = {hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.StallE, hz.StallM,
                hz.FlushD, hz.FlushE, hz.FlushW, hz.MemTimeout};

  typedef struct packed { ra_t ra1; ra_t ra2; ra_t wa3; logic rw; logic m2r; } e_rec_t;
  typedef struct packed { ra_t wa3; logic rw; logic m2r; logic acc; } m_rec_t;
  typedef struct packed { ra_t wa3; logic rw; } w_rec_t;

  e_rec_t m_e;
  m_rec_t m_m;
  w_rec_t m_w;
  int     m_waits;
  logic   m_tmo;

  logic        wait_c, lu_c;
  logic [6:0]  ctl_c;
  logic [11:0] exp_v;

  function automatic logic [1:0] fwd_of(ra_t src, m_rec_t mm, w_rec_t ww);
    if (src == 4'd15) return 2'b00;
    if (mm.rw && mm.wa3 == src) return 2'b10;
    if (ww.rw && ww.wa3 == src) return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    wait_c = m_m.acc && !hz.MemReady && !m_tmo;
    lu_c   = m_e.m2r && m_e.rw && (m_e.wa3 != 4'd15) &&
             (m_e.wa3 == hz.RA1D || m_e.wa3 == hz.RA2D);
    if (!RESET)           ctl_c = 7'b0000_110;
    else if (wait_c)      ctl_c = 7'b1111_001;
    else if (hz.PCSrcE)   ctl_c = 7'b0000_110;
    else if (lu_c)        ctl_c = 7'b1100_010;
    else                  ctl_c = 7'b0000_000;
    if (RESET) exp_v = {fwd_of(m_e.ra1, m_m, m_w), fwd_of(m_e.ra2, m_m, m_w), ctl_c, m_tmo};
    else       exp_v = {4'b0000, ctl_c, m_tmo};
  end

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      m_e <= '0; m_m <= '0; m_w <= '0; m_waits <= 0; m_tmo <= 1'b0;
    end else begin
      if (exp_v[5])      m_e <= m_e;
      else if (exp_v[2]) m_e <= '0;
      else m_e <= e_rec_t'({hz.RA1D, hz.RA2D, hz.WA3D, hz.RegWriteD, hz.MemtoRegD});
      if (!exp_v[4])
        m_m <= m_rec_t'({m_e.wa3, hz.RegWriteECond, m_e.m2r, m_e.m2r | hz.MemWriteECond});
      m_w     <= exp_v[1] ? w_rec_t'(0) : w_rec_t'({m_m.wa3, m_m.rw});
      m_waits <= wait_c ? m_waits + 1 : 0;
      if (wait_c && (m_waits + 1 == MEM_TIMEOUT_DEF)) m_tmo <= 1'b1;
    end
  end

  typedef struct packed {
    ra_t a1; ra_t a2; ra_t w3;
    logic rwd; logic m2rd; logic rwe; logic mwe; logic pcs; logic mrdy;
    logic [11:0] ev; logic [11:0] mv;
  } step_t;

  // ctl = {RegWriteD, MemtoRegD, RegWriteECond, MemWriteECond, PCSrcE}
  function automatic step_t mk(ra_t a1, ra_t a2, ra_t w3, logic [4:0] ctl, logic mrdy,
                               logic [11:0] ev, logic [11:0] mv);
    step_t s;
    s.a1 = a1; s.a2 = a2; s.w3 = w3;
    {s.rwd, s.m2rd, s.rwe, s.mwe, s.pcs} = ctl;
    s.mrdy = mrdy; s.ev = ev; s.mv = mv;
    return s;
  endfunction

  function automatic step_t idle();
    return mk(4'd0, 4'd0, 4'd0, 5'b00000, 1'b1, 12'h000, 12'h000);
  endfunction

  task automatic drv(input step_t s);
    hz.RA1D = s.a1; hz.RA2D = s.a2; hz.WA3D = s.w3;
    hz.RegWriteD = s.rwd; hz.MemtoRegD = s.m2rd;
    hz.RegWriteECond = s.rwe; hz.MemWriteECond = s.mwe;
    hz.PCSrcE = s.pcs; hz.MemReady = s.mrdy;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    #1;
    checks++;
    if (obs !== 12'h00C) $display("FAIL reset_outputs: got %h expected %h", obs, 12'h00C);
    else passed++;
    checks++;
    if (obs !== exp_v) $display("FAIL reset_model: got %h expected %h", obs, exp_v);
    else passed++;
    @(posedge CLK); @(posedge CLK); @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_forwarding();
    step_t q[$];
    q = {idle(), idle(), idle(),
         mk(4'd0, 4'd0, 4'd3, 5'b10000, 1'b1, 12'h000, 12'h000),
         mk(4'd3, 4'd7, 4'd0, 5'b00100, 1'b1, 12'h000, 12'h000),
         mk(4'd0, 4'd0, 4'd0, 5'b00000, 1'b1, 12'h800, 12'hFFE),
         idle(), idle(), idle(),
         mk(4'd0, 4'd0, 4'd3, 5'b10000, 1'b1, 12'h000, 12'h000),
         mk(4'd0, 4'd0, 4'd3, 5'b10100, 1'b1, 12'h000, 12'h000),
         mk(4'd0, 4'd3, 4'd3, 5'b10100, 1'b1, 12'h000, 12'h000),
         mk(4'd0, 4'd3, 4'd0, 5'b00000, 1'b1, 12'h200, 12'hFFE),
         mk(4'd0, 4'd0, 4'd0, 5'b00000, 1'b1, 12'h100, 12'hFFE)};
    foreach (q[i]) begin
      drv(q[i]);
      @(negedge CLK);
      checks++;
      if (obs !== exp_v) $display("FAIL fwd_model step %0d: got %h expected %h", i, obs, exp_v);
      else passed++;
      if (q[i].mv != 12'h000) begin
        checks++;
        if ((obs & q[i].mv) !== (q[i].ev & q[i].mv))
          $display("FAIL fwd_select step %0d: got %h expected %h", i, obs & q[i].mv, q[i].ev);
        else passed++;
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_load_use();
    step_t q[$];
    q = {idle(), idle(), idle(),
         mk(4'd0, 4'd0, 4'd5, 5'b11000, 1'b1, 12'h000, 12'h000),
         mk(4'd0, 4'd5, 4'd0, 5'b00100, 1'b1, 12'h0C4, 12'hFFE),
         mk(4'd0, 4'd5, 4'd0, 5'b00000, 1'b1, 12'h000, 12'hFFE),
         mk(4'd0, 4'd0, 4'd0, 5'b00000, 1'b1, 12'h100, 12'hFFE)};
    foreach (q[i]) begin
      drv(q[i]);
      @(negedge CLK);
      checks++;
      if (obs !== exp_v) $display("FAIL loaduse_model step %0d: got %h expected %h", i, obs, exp_v);
      else passed++;
      if (q[i].mv != 12'h000) begin
        checks++;
        if ((obs & q[i].mv) !== (q[i].ev & q[i].mv))
          $display("FAIL loaduse_stall step %0d: got %h expected %h", i, obs & q[i].mv, q[i].ev);
        else passed++;
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_branch();
    step_t q[$];
    q = {idle(), idle(), idle(),
         mk(4'd0, 4'd0, 4'd5, 5'b11000, 1'b1, 12'h000, 12'h000),
         mk(4'd5, 4'd0, 4'd0, 5'b00001, 1'b1, 12'h00C, 12'hFFE),
         mk(4'd0, 4'd0, 4'd0, 5'b00000, 1'b1, 12'h000, 12'hFFE)};
    foreach (q[i]) begin
      drv(q[i]);
      @(negedge CLK);
      checks++;
      if (obs !== exp_v) $display("FAIL branch_model step %0d: got %h expected %h", i, obs, exp_v);
      else passed++;
      if (q[i].mv != 12'h000) begin
        checks++;
        if ((obs & q[i].mv) !== (q[i].ev & q[i].mv))
          $display("FAIL branch_flush step %0d: got %h expected %h", i, obs & q[i].mv, q[i].ev);
        else passed++;
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_mem_wait();
    step_t q[$];
    q = {idle(), idle(), idle(),
         mk(4'd0, 4'd0, 4'd6, 5'b10000, 1'b1, 12'h000, 12'h000),
         mk(4'd6, 4'd0, 4'd0, 5'b00110, 1'b1, 12'h000, 12'h000),
         mk(4'd0, 4'd0, 4'd0, 5'b00000, 1'b0, 12'h8F2, 12'hFFF),
         mk(4'd0, 4'd0, 4'd0, 5'b00000, 1'b0, 12'h8F2, 12'hFFF),
         mk(4'd0, 4'd0, 4'd0, 5'b00000, 1'b0, 12'h8F2, 12'hFFF),
         mk(4'd0, 4'd0, 4'd0, 5'b00000, 1'b1, 12'h800, 12'hFFF),
         idle(), idle(), idle(),
         mk(4'd0, 4'd0, 4'd6, 5'b10000, 1'b1, 12'h000, 12'h000),
         mk(4'd6, 4'd0, 4'd0, 5'b00110, 1'b1, 12'h000, 12'h000),
         mk(4'd0, 4'd0, 4'd0, 5'b00000, 1'b0, 12'h8F2, 12'hFFF)};
    foreach (q[i]) begin
      drv(q[i]);
      @(negedge CLK);
      checks++;
      if (obs !== exp_v) $display("FAIL memwait_model step %0d: got %h expected %h", i, obs, exp_v);
      else passed++;
      if (q[i].mv != 12'h000) begin
        checks++;
        if ((obs & q[i].mv) !== (q[i].ev & q[i].mv))
          $display("FAIL memwait_stall step %0d: got %h expected %h", i, obs & q[i].mv, q[i].ev);
        else passed++;
      end
      @(posedge CLK); #1;
    end
    // still waiting here; reset must drop the stall without a clock edge
    drv(mk(4'd0, 4'd0, 4'd0, 5'b00000, 1'b0, 12'h000, 12'h000));
    #2 RESET = 1'b0;
    #1;
    checks++;
    if (obs !== 12'h00C) $display("FAIL reset_mid_stall: got %h expected %h", obs, 12'h00C);
    else passed++;
    @(posedge CLK);
    drv(idle());
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_timeout();
    step_t q[$];
    q = {idle(), idle(), idle(),
         mk(4'd0, 4'd0, 4'd9, 5'b11000, 1'b1, 12'h000, 12'h000),
         mk(4'd0, 4'd0, 4'd0, 5'b00100, 1'b1, 12'h000, 12'h000)};
    for (int k = 0; k < MEM_TIMEOUT_DEF; k++)
      q.push_back(mk(4'd0, 4'd0, 4'd0, 5'b00000, 1'b0, 12'h0F2, 12'hFFF));
    q.push_back(mk(4'd9, 4'd0, 4'd0, 5'b00000, 1'b0, 12'h001, 12'hFFF));
    q.push_back(mk(4'd0, 4'd0, 4'd0, 5'b00000, 1'b0, 12'h401, 12'hFFF));
    foreach (q[i]) begin
      drv(q[i]);
      @(negedge CLK);
      checks++;
      if (obs !== exp_v) $display("FAIL timeout_model step %0d: got %h expected %h", i, obs, exp_v);
      else passed++;
      if (q[i].mv != 12'h000) begin
        checks++;
        if ((obs & q[i].mv) !== (q[i].ev & q[i].mv))
          $display("FAIL timeout_seq step %0d: got %h expected %h", i, obs & q[i].mv, q[i].ev);
        else passed++;
      end
      @(posedge CLK); #1;
    end
    drv(idle());
    RESET = 1'b0;
    #1;
    checks++;
    if (obs !== 12'h00C) $display("FAIL timeout_reset: got %h expected %h", obs, 12'h00C);
    else passed++;
    @(posedge CLK); @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK); #1;
  endtask

  function automatic ra_t rnd_ra();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 4'd15 : ra_t'(r);
  endfunction

  task automatic test_random();
    step_t s;
    for (int i = 0; i < 400; i++) begin
      s = mk(rnd_ra(), rnd_ra(), rnd_ra(),
             {1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0),
              1'($urandom_range(0, 9) == 0)},
             1'($urandom_range(0, 3) != 0), 12'h000, 12'h000);
      drv(s);
      @(negedge CLK);
      checks++;
      if (obs !== exp_v) $display("FAIL random cycle %0d: got %h expected %h", i, obs, exp_v);
      else passed++;
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    RESET = 1'b1;
    drv(idle());
    #2;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard controller for the 5-stage core: Fetch, Decode, Execute, Memory, Writeback.
- Generates the ForwardAE/ForwardBE select codes consumed by the Execute stage's operand muxes.
- Generates the stall and flush controls for the pipeline registers.
- Keeps its own shadow pipeline of register addresses and write-enables for E/M/W, and enforces the data-memory wait handshake with a timeout.

Parameters:
- RA_W, 4, register address width.
- PC_REG, 15, register index that is never forwarded (PC).
- MEM_TIMEOUT, 16, maximum consecutive wait cycles before the timeout error.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- RA1D  in  RA_W  source register 1 of the instruction in Decode.
- RA2D  in  RA_W  source register 2 of the instruction in Decode.
- WA3D  in  RA_W  destination register in Decode.
- RegWriteD  in  1  Decode instruction writes a register.
- MemtoRegD  in  1  Decode instruction is a load.
- RegWriteECond  in  1  condition-qualified register write from Execute (RegWriteEOut).
- MemWriteECond  in  1  condition-qualified store from Execute.
- PCSrcE  in  1  taken branch / PC write resolved in Execute.
- MemReady  in  1  data memory completes the access in M this cycle.
- ForwardAE  out  2  SrcA select: 00 = RD1E, 01 = ResultW, 10 = ALUResultM.
- ForwardBE  out  2  SrcB select, same encoding.
- StallF, StallD, StallE, StallM  out  1 each  hold the stage register.
- FlushD, FlushE, FlushW  out  1 each  load a bubble into the stage register.
- MemTimeout  out  1  sticky error flag.

Behaviour:
- Shadow state:
  - E stage: RA1E, RA2E, WA3E, RegWriteE, MemtoRegE.
  - M stage: WA3M, RegWriteM, MemtoRegM, MemAccessM.
  - W stage: WA3W, RegWriteW.
  - Wait counter WaitCnt, 0..MEM_TIMEOUT.
- Reset (RESET low):
  - All shadow state, WaitCnt and MemTimeout cleared.
  - Outputs: ForwardAE = ForwardBE = 00; all Stall = 0; FlushD = FlushE = 1; FlushW = 0.
- Shadow E update:
  - If StallE, hold.
  - Else if FlushE, clear to zeros.
  - Else load RA1D, RA2D, WA3D, RegWriteD, MemtoRegD.
- Shadow M update (if StallM, hold):
  - Load WA3M = WA3E, RegWriteM = RegWriteECond, MemtoRegM = MemtoRegE.
  - MemAccessM = MemtoRegE | MemWriteECond.
- Shadow W update:
  - If FlushW, clear.
  - Else load WA3W = WA3M and RegWriteW = RegWriteM.
- Forwarding (combinational from shadow state, same cycle):
  - ForwardAE = 10 if RegWriteM and WA3M == RA1E and RA1E != PC_REG.
  - Else 01 if RegWriteW and WA3W == RA1E and RA1E != PC_REG.
  - Else 00. ForwardBE identical using RA2E.
  - M has priority over W.
- Priority of controls, highest first:
  1. Memory wait: MemWait = MemAccessM & ~MemReady & ~MemTimeout.
     - StallF = StallD = StallE = StallM = 1, FlushW = 1.
     - FlushD = FlushE = 0; branch and load-use decisions are deferred because E is held.
  2. Branch: PCSrcE = 1.
     - FlushD = FlushE = 1, all stalls 0; a load-use stall on the flushed Decode instruction is suppressed.
  3. Load-use: MemtoRegE & RegWriteE & WA3E != PC_REG & (WA3E == RA1D or WA3E == RA2D).
     - StallF = StallD = 1, FlushE = 1.
  4. Otherwise all stalls and flushes are 0.
- Wait counter:
  - Increments each cycle MemWait = 1 and resets to 0 otherwise.
  - When WaitCnt reaches MEM_TIMEOUT-1 while waiting, MemTimeout sets on the next edge.
  - MemTimeout is sticky until reset; once set, MemWait is masked and the pipeline proceeds.
- Reset mid-stall: all controls return to their reset values immediately (asynchronous reset).
- No internal latency on outputs: every output is a combinational function of registered state and current inputs.

Decomposition:
- Shared package hazard_pkg:
  - fwd_sel_t enum with FWD_RD = 2'b00, FWD_RESULTW = 2'b01, FWD_ALUM = 2'b10.
  - PC_REG constant.
  - ra_t typedef logic [RA_W-1:0].
- One sub-module fwd_select: compares one source address against the M and W shadow state and returns fwd_sel_t.
  - Instantiated twice, for A and B.

Test Plan:
1. ALU write to R3 in M, Execute reads RA1E = 3 -> ForwardAE = 10, ForwardBE = 00.
2. R3 written by both M and W, RA2E = 3 -> ForwardBE = 10. With RegWriteM = 0 -> ForwardBE = 01.
3. Load to R5 in E, Decode RA2D = 5 -> exactly one cycle of StallF = StallD = FlushE = 1, then ForwardBE = 01 on the following cycle.
4. PCSrcE = 1 with a concurrent load-use match -> FlushD = FlushE = 1, StallF = StallD = 0.
5. Load in M, MemReady low 3 cycles -> StallF/D/E/M = 1 and FlushW = 1 for 3 cycles, then released; ForwardAE is unchanged throughout.
6. MemReady held low, MEM_TIMEOUT = 16 -> MemTimeout rises after 16 wait cycles and stalls drop. RESET low -> MemTimeout = 0, all forward selects = 00.
